video_counters: RTL

VIDEO_COUNTERS -- requirements
Module: video_counters

---
 rtl/video_counters.sv | 120 ++++++++++++
 1 files changed

// File: rtl/video_counters.sv
// VIC-II style video counters: VC/VCBASE/RC/VMLI, display/idle state and DRAM refresh counter.
// All state advances only on phase_end ticks of the 4x dot clock.
module video_counters #(
    parameter int CYCLE_VC_LOAD = 14,
    parameter int CYCLE_RC_UPD  = 58
) (
    input  logic       clk_dot4x,
    input  logic       rst,
    input  logic       phase_end,
    input  logic       phi,
    input  logic [6:0] cycle_num,
    input  logic [8:0] raster_line,
    input  logic       badline,
    input  logic [3:0] cycle_type,
    output logic [9:0] vc,
    output logic [9:0] vcbase,
    output logic [2:0] rc,
    output logic [5:0] vmli,
    output logic       idle,
    output logic [7:0] refc
);

    // Cycle type codes shared with the sequencer.
    localparam logic [3:0] VIC_LR = 4'd3;
    localparam logic [3:0] VIC_LG = 4'd4;

    logic [9:0] vc_q, vc_d;
    logic [9:0] vcbase_q, vcbase_d;
    logic [2:0] rc_q, rc_d;
    logic [5:0] vmli_q, vmli_d;
    logic       idle_q, idle_d;
    logic [7:0] refc_q, refc_d;

    logic frame_start;
    logic vc_load;
    logic line_end;
    logic g_access;
    logic refresh;

    always_comb begin
        frame_start = phase_end && !phi && (raster_line == 9'd0) && (cycle_num == 7'd1);
        vc_load     = phase_end && !phi && (cycle_num == 7'(CYCLE_VC_LOAD));
        line_end    = phase_end && !phi && (cycle_num == 7'(CYCLE_RC_UPD));
        g_access    = phase_end && (cycle_type == VIC_LG) && !idle_q;
        refresh     = phase_end && (cycle_type == VIC_LR);
    end

    always_comb begin
        vc_d     = vc_q;
        vcbase_d = vcbase_q;
        rc_d     = rc_q;
        vmli_d   = vmli_q;
        idle_d   = idle_q;
        refc_d   = refc_q;

        if (g_access) begin
            vc_d   = vc_q + 10'd1;
            vmli_d = vmli_q + 6'd1;
        end

        // Line end latches the pre-increment vc into vcbase.
        if (line_end) begin
            if (rc_q == 3'd7) begin
                vcbase_d = vc_q;
                idle_d   = 1'b1;
            end
            if (!idle_q) begin
                rc_d = rc_q + 3'd1;
            end
        end

        // Loading from the pre-edge vcbase keeps a coincident frame start from leaking in.
        if (vc_load) begin
            vc_d   = vcbase_q;
            vmli_d = 6'd0;
            if (badline) begin
                rc_d = 3'd0;
            end
        end

        if (phase_end && badline) begin
            idle_d = 1'b0;
        end

        if (refresh) begin
            refc_d = refc_q - 8'd1;
        end

        if (frame_start) begin
            vcbase_d = 10'd0;
            refc_d   = 8'hFF;
        end
    end

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            vc_q     <= 10'd0;
            vcbase_q <= 10'd0;
            rc_q     <= 3'd0;
            vmli_q   <= 6'd0;
            idle_q   <= 1'b1;
            refc_q   <= 8'hFF;
        end else begin
            vc_q     <= vc_d;
            vcbase_q <= vcbase_d;
            rc_q     <= rc_d;
            vmli_q   <= vmli_d;
            idle_q   <= idle_d;
            refc_q   <= refc_d;
        end
    end

    assign vc     = vc_q;
    assign vcbase = vcbase_q;
    assign rc     = rc_q;
    assign vmli   = vmli_q;
    assign idle   = idle_q;
    assign refc   = refc_q;

endmodule
